cell_automaton_gen: RTL and testbench
=====================================

Name: cell_automaton_gen

Overview:
- Parametrised 1-D elementary cellular-automaton drawing engine.
- Fixed rule 150 → any Wolfram rule (8-bit, latched at start); configurable line width, line count, seed pixel and colours.
- Draws one row per display line, top to bottom, via the drawing-engine handshake (de_req/de_ack) to the frame store.
- Two ping-pong line buffers hold the current row and build the next row as each word is emitted.

Parameters:
- COLS_WORDS, 160, 32-bit words per line (4 pixels/word, 1 byte/pixel); PIX = 4*COLS_WORDS
- ROWS, 480, lines drawn per frame
- BASE_ADDR, 18'h0, word address of row 0 word 0
- STRIDE, 160, word address step between rows (≥ COLS_WORDS)
- FG_COLOUR, 8'hFF, byte written for a live cell
- BG_COLOUR, 8'h00, byte written for a dead cell

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  1  start request (sampled only when idle)
- ack  out  1  one-cycle pulse accepting req
- busy  out  1  high from cycle after ack until last word acknowledged
- rule  in  8  Wolfram rule; latched on accepted req
- seed_pos  in  PIX_W=$clog2(PIX)  index of the single live pixel in row 0; latched on accepted req
- de_req  out  1  write request to drawing engine
- de_ack  in  1  write accepted
- de_addr  out  18  word address
- de_nbyte  out  4  active-low byte enables
- de_w_data  out  32  pixel data, lane i = bits 8i+7:8i = pixel 4w+i

Behaviour:
- Reset (async, rst=1): ack=0, busy=0, de_req=0, de_addr=0, de_nbyte=4'hF, de_w_data=0; FSM→IDLE; buffers are not cleared.
- Clock/reset: one clock clk, rising edge only; rst asynchronous active-high.
- FSM states: IDLE, SEED, EMIT, WAIT, DONE.
- IDLE:
  - req=1 → ack=1 for one cycle, latch rule and seed_pos, → SEED.
  - req while busy is ignored; no ack.
- SEED:
  - Clears current buffer over one pass, then sets bit seed_pos; row=0, word=0 → EMIT.
  - seed_pos ≥ PIX → row 0 all dead.
  - Allowed to take COLS_WORDS cycles.
- EMIT:
  - Drive de_addr = BASE_ADDR + row*STRIDE + word; de_nbyte=4'b0000; lane i = cur[4w+i] ? FG_COLOUR : BG_COLOUR.
  - Assert de_req → WAIT.
- WAIT:
  - de_req, de_addr, de_w_data held stable until de_ack=1 sampled.
  - On de_ack: de_req=0 next cycle; next-row nibble for word w written into the other buffer.
  - Bit i = rule[{cur[p-1],cur[p],cur[p+1]}], p=4w+i.
  - Advance word; at word = COLS_WORDS-1: swap buffers, row++, word=0.
  - At row = ROWS-1 → DONE; otherwise → EMIT (de_req low ≥1 cycle between words).
- DONE: busy=0, → IDLE.
- Boundary pixels (p=0 left, p=PIX-1 right): neighbour outside the line reads 0, unless CA_WRAP_EN.
- Row/word counters: unsigned, widths $clog2(ROWS), $clog2(COLS_WORDS); de_addr arithmetic truncated to 18 bits.
- de_ack while de_req=0 is ignored.
- Reset mid-frame abandons the frame; de_req drops immediately.

Optional Feature:
- CA_WRAP_EN defined: toroidal line; pixel 0's left neighbour = pixel PIX-1, and pixel PIX-1's right neighbour = pixel 0.
- Undefined: out-of-line neighbours are 0.

Decomposition:
- Package ca_pkg: FSM state enum, PIX/PIX_W derivation helper, lane-to-pixel mapping constants.
- Sub-module ca_rule_slice (combinational): 6 cell bits + rule[7:0] → 4 next-gen bits; instantiated once on the selected word.

Test Plan (COLS_WORDS=4, ROWS=3, STRIDE=4, BASE_ADDR=0):
1. Rule 90, seed_pos=8:
   - Row 0: addr 2 = 0x000000FF.
   - Row 1: addr 5 = 0xFF000000, addr 6 = 0x0000FF00.
   - Row 2: addr 9 = 0x00FF0000, addr 10 = 0x00FF0000.
   - All other words 0x00000000, 12 writes total.
   - busy falls after the 12th ack.
2. Rule 0, seed_pos=8 → rows 1–2 all twelve-minus-four words 0x00000000; row 0 as in scenario 1.
3. de_ack delayed 5 cycles on every write → de_req/de_addr/de_w_data stable throughout; identical data sequence.
4. req pulsed while busy → no ack; frame completes unchanged.
5. rst asserted after 6th de_ack → de_req, busy low immediately. New req, rule 90 → full correct frame from row 0.
6. Rule 90, seed_pos=0:
   - CA_WRAP_EN defined: row 1 addr 4 = 0x0000FF00, addr 7 = 0xFF000000.
   - CA_WRAP_EN undefined: addr 7 = 0x00000000.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and helpers for the elementary cellular-automaton line engine.
package ca_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_EMIT,
    S_WAIT,
    S_DONE
  } state_t;

  // Each 32-bit word carries 4 one-byte pixels; lane i is pixel 4w+i.
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  function automatic int pix_of(input int cols_words);
    return LANES * cols_words;
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ca_rule_slice.sv
// Next-generation bits for one word: 4 cells plus one neighbour on each side.
module ca_rule_slice
  import ca_pkg::*;
(
  input  logic [LANES+1:0] win,
  input  logic [7:0]       rule,
  output logic [LANES-1:0] nxt
);

  // win[i] is the left neighbour of lane i, win[i+2] its right neighbour.
  always_comb begin
    nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      nxt[i] = rule[{win[i], win[i+1], win[i+2]}];
    end
  end

endmodule

// File: rtl/cell_automaton_gen.sv
// Draws ROWS generations of a 1-D Wolfram-rule automaton, one word per de_req/de_ack write.
// Define CA_WRAP_EN for a toroidal line; otherwise cells beyond either end read as dead.
module cell_automaton_gen
  import ca_pkg::*;
#(
  parameter int          COLS_WORDS = 160,
  parameter int          ROWS       = 480,
  parameter logic [17:0] BASE_ADDR  = 18'h0,
  parameter int          STRIDE     = 160,
  parameter logic [7:0]  FG_COLOUR  = 8'hFF,
  parameter logic [7:0]  BG_COLOUR  = 8'h00,
  localparam int         PIX        = pix_of(COLS_WORDS),
  localparam int         PIX_W      = $clog2(PIX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             ack,
  output logic             busy,
  input  logic [7:0]       rule,
  input  logic [PIX_W-1:0] seed_pos,
  output logic             de_req,
  input  logic             de_ack,
  output logic [17:0]      de_addr,
  output logic [3:0]       de_nbyte,
  output logic [31:0]      de_w_data
);

  localparam int ROW_W  = width_of(ROWS);
  localparam int WORD_W = width_of(COLS_WORDS);

  state_t              state_q, state_d;
  logic                ack_q, ack_d, busy_q, busy_d, de_req_q, de_req_d;
  logic [17:0]         de_addr_q, de_addr_d;
  logic [3:0]          de_nbyte_q, de_nbyte_d;
  logic [31:0]         de_w_data_q, de_w_data_d;
  logic [7:0]          rule_q, rule_d;
  logic [PIX_W-1:0]    seed_q, seed_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                sel_q, sel_d;
  logic [PIX-1:0]      buf0_q, buf0_d, buf1_q, buf1_d;

  logic [PIX-1:0]      cur, seed_vec;
  logic [PIX+1:0]      ext;
  logic [LANES+1:0]    win;
  logic [LANES-1:0]    cur_nib, nxt_nib;
  logic                last_word, last_row;

  assign cur       = sel_q ? buf1_q : buf0_q;
  assign cur_nib   = cur[LANES*int'(word_q) +: LANES];
  assign win       = ext[LANES*int'(word_q) +: LANES+2];
  assign last_word = (word_q == WORD_W'(COLS_WORDS - 1));
  assign last_row  = (row_q == ROW_W'(ROWS - 1));

  // ext[0] and ext[PIX+1] stand in for the cells just outside the line.
`ifdef CA_WRAP_EN
  assign ext = {cur[0], cur, cur[PIX-1]};
`else
  assign ext = {1'b0, cur, 1'b0};
`endif

  always_comb begin
    seed_vec = '0;
    if (int'(seed_q) < PIX) seed_vec[seed_q] = 1'b1;
  end

  ca_rule_slice u_slice (
    .win  (win),
    .rule (rule_q),
    .nxt  (nxt_nib)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_SEED;
      S_SEED:  state_d = S_EMIT;
      S_EMIT:  state_d = S_WAIT;
      S_WAIT:  if (de_ack) state_d = (last_word && last_row) ? S_DONE : S_EMIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d       = 1'b0;
    busy_d      = busy_q;
    de_req_d    = de_req_q;
    de_addr_d   = de_addr_q;
    de_nbyte_d  = de_nbyte_q;
    de_w_data_d = de_w_data_q;
    rule_d      = rule_q;
    seed_d      = seed_q;
    row_d       = row_q;
    word_d      = word_q;
    sel_d       = sel_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          ack_d  = 1'b1;
          rule_d = rule;
          seed_d = seed_pos;
        end
      end
      S_SEED: begin
        busy_d = 1'b1;
        sel_d  = 1'b0;
        buf0_d = seed_vec;
        row_d  = '0;
        word_d = '0;
      end
      S_EMIT: begin
        de_req_d   = 1'b1;
        de_addr_d  = BASE_ADDR + 18'(int'(row_q) * STRIDE) + 18'(word_q);
        de_nbyte_d = 4'b0000;
        for (int i = 0; i < LANES; i++) begin
          de_w_data_d[LANE_W*i +: LANE_W] = cur_nib[i] ? FG_COLOUR : BG_COLOUR;
        end
      end
      S_WAIT: begin
        if (de_ack) begin
          de_req_d = 1'b0;
          // The next row is built in whichever buffer is not being displayed.
          if (sel_q) buf0_d[LANES*int'(word_q) +: LANES] = nxt_nib;
          else       buf1_d[LANES*int'(word_q) +: LANES] = nxt_nib;
          if (last_word) begin
            word_d = '0;
            row_d  = row_q + 1'b1;
            sel_d  = ~sel_q;
            if (last_row) busy_d = 1'b0;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_DONE:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      de_req_q    <= 1'b0;
      de_addr_q   <= '0;
      de_nbyte_q  <= 4'hF;
      de_w_data_q <= '0;
      rule_q      <= '0;
      seed_q      <= '0;
      row_q       <= '0;
      word_q      <= '0;
      sel_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      de_req_q    <= de_req_d;
      de_addr_q   <= de_addr_d;
      de_nbyte_q  <= de_nbyte_d;
      de_w_data_q <= de_w_data_d;
      rule_q      <= rule_d;
      seed_q      <= seed_d;
      row_q       <= row_d;
      word_q      <= word_d;
      sel_q       <= sel_d;
    end
  end

  // Line buffers keep their contents across reset; SEED rewrites them before use.
  always_ff @(posedge clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign de_req    = de_req_q;
  assign de_addr   = de_addr_q;
  assign de_nbyte  = de_nbyte_q;
  assign de_w_data = de_w_data_q;

endmodule

// File: tb/tb_cell_automaton_gen.sv
// Directed bench for cell_automaton_gen on a 4-word x 3-row frame.
module tb_cell_automaton_gen;

  localparam int NW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        de_ack = 1'b0;
  logic [7:0]  rule = 8'd0;
  logic [3:0]  seed_pos = 4'd0;
  logic        ack, busy, de_req;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_w_data;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem     [NW];
  logic [31:0] exp_mem [NW];
  int          n_wr;
  bit          stable_ok;
  bit          ack_seen;

  cell_automaton_gen #(
    .COLS_WORDS (4),
    .ROWS       (3),
    .BASE_ADDR  (18'h0),
    .STRIDE     (4),
    .FG_COLOUR  (8'hFF),
    .BG_COLOUR  (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .busy      (busy),
    .rule      (rule),
    .seed_pos  (seed_pos),
    .de_req    (de_req),
    .de_ack    (de_ack),
    .de_addr   (de_addr),
    .de_nbyte  (de_nbyte),
    .de_w_data (de_w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Request a frame, then change rule/seed inputs to prove they were latched.
  task automatic start(input logic [7:0] r, input logic [3:0] s);
    @(negedge clk);
    rule = r; seed_pos = s; req = 1'b1;
    @(negedge clk);
    req = 1'b0; rule = ~r; seed_pos = ~s;
    chk("ack_pulse", 32'(ack), 32'd1);
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd1);
  endtask

  // Acknowledge up to max_wr writes, each held off by dly cycles.
  task automatic collect(input int dly, input int max_wr, input bit pulse);
    int          guard;
    logic [17:0] a;
    logic [31:0] d;
    guard = 0; n_wr = 0; stable_ok = 1'b1; ack_seen = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = 32'hDEADBEEF;
    while (n_wr < max_wr && guard < 3000) begin
      if (pulse) req = (n_wr == 3);
      if (de_req === 1'b1) begin
        a = de_addr; d = de_w_data;
        if (de_nbyte !== 4'h0) stable_ok = 1'b0;
        for (int k = 0; k < dly; k++) begin
          @(negedge clk); guard++;
          if (ack === 1'b1) ack_seen = 1'b1;
          if (de_req !== 1'b1 || de_addr !== a || de_w_data !== d) stable_ok = 1'b0;
        end
        de_ack = 1'b1;
        @(negedge clk); guard++;
        de_ack = 1'b0;
        if (ack === 1'b1) ack_seen = 1'b1;
        if (int'(a) < NW) mem[int'(a)] = d;
        else stable_ok = 1'b0;
        n_wr++;
      end else begin
        @(negedge clk); guard++;
        if (ack === 1'b1) ack_seen = 1'b1;
      end
    end
    req = 1'b0;
    chk("write_count", 32'(n_wr), 32'(max_wr));
    chk("hold_stable", 32'(stable_ok), 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    bit extra;
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    for (int i = 0; i < NW; i++) chk($sformatf("%s_w%0d", tag, i), mem[i], exp_mem[i]);
    extra = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (de_req !== 1'b0) extra = 1'b1;
    end
    chk({tag, "_no_extra"}, 32'(extra), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_de_req"}, 32'(de_req), 32'd0);
    chk({tag, "_addr"}, 32'(de_addr), 32'd0);
    chk({tag, "_nbyte"}, 32'(de_nbyte), 32'hF);
    chk({tag, "_data"}, de_w_data, 32'd0);
  endtask

  initial begin
    int wguard;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Rule 90 from pixel 8: two diverging diagonals.
    exp_mem = '{32'h0, 32'h0, 32'h000000FF, 32'h0,
                32'h0, 32'hFF000000, 32'h0000FF00, 32'h0,
                32'h0, 32'h00FF0000, 32'h00FF0000, 32'h0};
    start(8'd90, 4'd8);
    collect(0, NW, 1'b0);
    finish_frame("r90");

    // Rule 0 kills everything after row 0.
    exp_mem = '{32'h0, 32'h0, 32'h000000FF, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0};
    start(8'd0, 4'd8);
    collect(0, NW, 1'b0);
    finish_frame("r0");

    // Slow drawing engine, then req pulsed while busy.
    exp_mem = '{32'h0, 32'h0, 32'h000000FF, 32'h0,
                32'h0, 32'hFF000000, 32'h0000FF00, 32'h0,
                32'h0, 32'h00FF0000, 32'h00FF0000, 32'h0};
    start(8'd90, 4'd8);
    collect(5, NW, 1'b0);
    finish_frame("slow");

    start(8'd90, 4'd8);
    collect(0, NW, 1'b1);
    chk("no_ack_while_busy", 32'(ack_seen), 32'd0);
    finish_frame("busyreq");

    // Reset while the 7th write is outstanding.
    start(8'd90, 4'd8);
    collect(0, 6, 1'b0);
    wguard = 0;
    while (de_req !== 1'b1 && wguard < 20) begin
      @(negedge clk); wguard++;
    end
    chk("seventh_req_seen", 32'(de_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drops_de_req", 32'(de_req), 32'd0);
    chk("rst_drops_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    start(8'd90, 4'd8);
    collect(0, NW, 1'b0);
    finish_frame("after_rst");

    // Seed at the left edge exercises the boundary neighbours.
`ifdef CA_WRAP_EN
    exp_mem = '{32'h000000FF, 32'h0, 32'h0, 32'h0,
                32'h0000FF00, 32'h0, 32'h0, 32'hFF000000,
                32'h00FF0000, 32'h0, 32'h0, 32'h00FF0000};
`else
    exp_mem = '{32'h000000FF, 32'h0, 32'h0, 32'h0,
                32'h0000FF00, 32'h0, 32'h0, 32'h0,
                32'h00FF00FF, 32'h0, 32'h0, 32'h0};
`endif
    start(8'd90, 4'd0);
    collect(0, NW, 1'b0);
    finish_frame("edge");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
